// File: rtl/linear_network_multicast_pipe.sv
// -----------------------------------------------------------------------------
// linear_network_multicast_pipe
//
// Purpose:
//   A linear chain of NUM_NODE pipeline stages S0..S(N-1). Stage k drives output
//   node k. A packet enters S0 with a destination mask and moves down the chain.
//   At stage k it is delivered to node k when mask bit k is set, and it is
//   forwarded to stage k+1 while any mask bit above k is still set. Delivery and
//   forwarding can complete in different cycles. Each completed part clears its
//   mask bits, so no node receives a packet twice.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   i_en        network enable; low freezes every stage and gates all outputs
//   i_valid     source packet valid
//   o_ready     source may transfer (handshake on i_valid & o_ready)
//   i_data_bus  source payload, DATA_WIDTH bits
//   i_dest      destination mask, bit k selects node k
//   o_valid     per-node delivery valid
//   i_ready     per-node sink ready
//   o_data_bus  node k payload on [k*DATA_WIDTH +: DATA_WIDTH], zero when idle
//   o_busy      high when any stage holds a packet
// -----------------------------------------------------------------------------
module linear_network_multicast_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_NODE   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_en,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [DATA_WIDTH-1:0]          i_data_bus,
  input  logic [NUM_NODE-1:0]            i_dest,
  output logic [NUM_NODE-1:0]            o_valid,
  input  logic [NUM_NODE-1:0]            i_ready,
  output logic [DATA_WIDTH*NUM_NODE-1:0] o_data_bus,
  output logic                           o_busy
);

  localparam int N = NUM_NODE;

  typedef logic [N-1:0] mask_t;

  // Mask with every bit strictly above position k set. These are the nodes that
  // are still downstream of stage k.
  function automatic mask_t above_mask(input int k);
    mask_t m;
    for (int j = 0; j < N; j++) begin
      m[j] = (j > k);
    end
    return m;
  endfunction

  // Stage state
  logic [N-1:0]          valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q [N];
  logic [DATA_WIDTH-1:0] data_d [N];
  mask_t                 mask_q [N];
  mask_t                 mask_d [N];

  // Per-stage handshake terms
  logic [N-1:0]          deliver_s;    // node k takes Sk this cycle
  logic [N-1:0]          fwd_need_s;   // Sk still has downstream destinations
  logic [N-1:0]          accept_s;     // Sk loads from upstream (source for S0)
  logic [N-1:0]          fwd_taken_s;  // S(k+1) accepts from Sk this cycle
  logic [N-1:0]          done_s;       // Sk finished all of its work this cycle
  logic                  ready_s;

  // Upstream view seen by each stage: the source for S0, S(k-1) for the rest.
  logic [DATA_WIDTH-1:0] up_data_s [N];
  mask_t                 up_mask_s [N];

  // Ready/done chain. It is evaluated from the last stage back to S0, so the
  // sink readies reach o_ready through combinational logic only. i_valid is
  // used only after ready_s has been formed.
  always_comb begin
    o_valid     = '0;
    deliver_s   = '0;
    fwd_need_s  = '0;
    accept_s    = '0;
    fwd_taken_s = '0;
    done_s      = '0;
    ready_s     = 1'b0;

    for (int k = 0; k < N; k++) begin
      o_valid[k]    = i_en & valid_q[k] & mask_q[k][k];
      deliver_s[k]  = o_valid[k] & i_ready[k];
      fwd_need_s[k] = |(mask_q[k] & above_mask(k));
    end

    // The last stage has no downstream neighbour, so only delivery matters.
    done_s[N-1] = i_en & valid_q[N-1] & (~mask_q[N-1][N-1] | deliver_s[N-1]);

    for (int k = N - 2; k >= 0; k--) begin
      accept_s[k+1]  = i_en & valid_q[k] & fwd_need_s[k] &
                       (~valid_q[k+1] | done_s[k+1]);
      fwd_taken_s[k] = accept_s[k+1];
      done_s[k]      = i_en & valid_q[k] &
                       (~mask_q[k][k] | deliver_s[k]) &
                       (~fwd_need_s[k] | accept_s[k+1]);
    end

    // rst_n is included so o_ready is low for the whole time reset is held.
    ready_s = rst_n & i_en & (~valid_q[0] | done_s[0]);

    // A packet with an empty destination mask is taken and dropped. It never
    // occupies S0.
    accept_s[0] = i_valid & ready_s & (|i_dest);
  end

  assign o_ready = ready_s;

  // Upstream payload and mask for each stage. A forwarded mask loses bits
  // [k-1:0] of the sending stage, which includes the node that stage serves.
  always_comb begin
    up_data_s[0] = i_data_bus;
    up_mask_s[0] = i_dest;
    for (int k = 1; k < N; k++) begin
      up_data_s[k] = data_q[k-1];
      up_mask_s[k] = mask_q[k-1] & above_mask(k - 1);
    end
  end

  // Next state for each stage: reload, empty when done, or partial progress.
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < N; k++) begin
      data_d[k] = data_q[k];
      mask_d[k] = mask_q[k];

      if (accept_s[k]) begin
        // A reload takes priority. The previous packet, if any, is done this cycle.
        valid_d[k] = 1'b1;
        data_d[k]  = up_data_s[k];
        mask_d[k]  = up_mask_s[k];
      end else if (done_s[k]) begin
        valid_d[k] = 1'b0;
        mask_d[k]  = '0;
      end else begin
        // Partial progress. Drop only the parts that completed this cycle.
        if (deliver_s[k]) begin
          mask_d[k][k] = 1'b0;
        end else begin
          mask_d[k][k] = mask_q[k][k];
        end
        if (fwd_taken_s[k]) begin
          mask_d[k] = mask_d[k] & ~above_mask(k);
        end else begin
          mask_d[k] = mask_d[k];
        end
      end
    end
  end

  // Stage registers. While i_en is low no handshake term is active, so the
  // next state equals the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < N; k++) begin
        data_q[k] <= '0;
        mask_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < N; k++) begin
        data_q[k] <= data_d[k];
        mask_q[k] <= mask_d[k];
      end
    end
  end

  // Payload fan-out. A slice carries data only while its node valid is high.
  always_comb begin
    o_data_bus = '0;
    for (int k = 0; k < N; k++) begin
      if (o_valid[k]) begin
        o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] = data_q[k];
      end else begin
        o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  // Occupancy flag. It reflects stage contents even while i_en is low.
  assign o_busy = |valid_q;

endmodule

// File: doc/linear_network_multicast_pipe.md
LINEAR_NETWORK_MULTICAST_PIPE -- requirements
Module: linear_network_multicast_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, payload width in bits; SHALL accept any value >= 1.
REQ-002 Parameter NUM_NODE, default 4, number of chained output nodes; SHALL accept any value >= 2; no width or node count hardcoded.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 i_en  input  1  network enable; low freezes the pipeline.
REQ-007 i_valid  input  1  source packet valid.
REQ-008 o_ready  output  1  source may transfer; handshake when i_valid & o_ready.
REQ-009 i_data_bus  input  DATA_WIDTH  source payload.
REQ-010 i_dest  input  NUM_NODE  destination mask; bit k selects node k; one-hot = unicast, multi-hot = multicast.
REQ-011 o_valid  output  NUM_NODE  per-node delivery valid.
REQ-012 i_ready  input  NUM_NODE  per-node sink ready; node k delivery occurs when o_valid[k] & i_ready[k].
REQ-013 o_data_bus  output  DATA_WIDTH*NUM_NODE  node k payload on [k*DATA_WIDTH+:DATA_WIDTH].
REQ-014 o_busy  output  1  high when any stage holds a packet.

Function
REQ-015 SHALL contain NUM_NODE stage registers S0..S(N-1), each holding valid, DATA_WIDTH payload, and NUM_NODE-bit pending mask.
REQ-016 o_valid[k] SHALL equal i_en & Sk.valid & Sk.mask[k]; o_data_bus slice k SHALL be Sk.data when o_valid[k], else all zeros.
REQ-017 Sk "done" in a cycle: (mask[k]==0 or node-k delivery this cycle) and (mask[N-1:k+1]==0 or S(k+1) accepts this cycle).
REQ-018 S(k+1) SHALL accept from Sk when i_en, Sk.valid, Sk.mask[N-1:k+1]!=0, and (S(k+1) empty or S(k+1) done this cycle); accepted mask SHALL be Sk.mask with bits [k:0] cleared.
REQ-019 o_ready SHALL be i_en & (S0 empty or S0 done this cycle); S0 loads {1, i_data_bus, i_dest} on handshake.
REQ-020 Packet with i_dest==0 SHALL be consumed on handshake (o_ready unaffected) and SHALL NOT load S0.
REQ-021 Partial progress: if node-k delivery occurs but forwarding stalls, Sk SHALL clear mask[k] (no duplicate delivery); if forwarding occurs but delivery stalls, Sk SHALL clear mask[N-1:k+1].
REQ-022 Sk SHALL become empty on the edge it is done, unless simultaneously reloaded by S(k-1) (or the source for S0), in which case it takes the new packet.
REQ-023 Latency without stalls: packet accepted at edge t SHALL present o_valid[k] during cycle after edge t+k; throughput one packet per cycle.
REQ-024 Per-node delivery order SHALL equal source acceptance order; no packet dropped or duplicated.
REQ-025 i_en low: no state change, o_valid all 0, o_ready 0, o_data_bus all 0; o_busy still reflects contents; resume unchanged when i_en returns high.
REQ-026 o_busy SHALL be OR of all Sk.valid.
REQ-027 Ready chain combinational from i_ready back to o_ready; no combinational path from i_valid to o_ready.

Reset
REQ-028 rst_n low SHALL immediately clear every Sk.valid, mask, and data; o_valid=0, o_ready=0, o_busy=0, o_data_bus=0 while asserted.
REQ-029 Reset mid-packet SHALL discard all in-flight packets; first cycle after release with i_en=1 SHALL show o_ready=1.

Verification
REQ-030 N=4, D=32, all i_ready=1: send 0xA5A5A5A5 with i_dest=4'b0100 -> o_valid=4'b0100 two cycles after acceptance edge, slice 2 = 0xA5A5A5A5, other slices 0.
REQ-031 Multicast i_dest=4'b1011, data 0x11: node0 at t+0, node1 at t+1, node3 at t+3, node2 never; each exactly once.
REQ-032 Back-to-back 8 packets, one-hot destinations cycling 0..3, i_ready=1: o_ready held 1, one delivery per cycle, in-order per node.
REQ-033 i_ready[1]=0 for 5 cycles with i_dest=4'b1010 streaming: node3 still receives first packet; S1 holds with mask bit1 only; upstream o_ready drops once S0,S1 full; no duplicates after release.
REQ-034 i_dest=0 accepted -> no o_valid asserted, o_busy stays 0; i_en=0 mid-stream freezes state for 3 cycles then resumes with identical delivery sequence.
REQ-035 rst_n pulsed low asynchronously with 3 packets in flight -> outputs 0 immediately; none of those packets delivered after release.
